// File: rtl/vc_demux_fifo.sv
// Two-lane virtual-channel demux: ingress words are steered by bit 8
// into one of two FIFOs, each drained onto its own pausable lane.

module vc_fifo #(
    parameter int DATA_W    = 10,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] din,
    input  logic              pause,
    output logic [DATA_W-1:0] dout,
    output logic              empty_f,
    output logic              full,
    output logic              almost_full,
    output logic              overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic              is_full;
    logic              is_empty;
    logic              wr_en;
    logic              rd_en;

    // Full/empty come from the pre-edge count, so a pop never frees
    // a slot for a push in the same cycle.
    assign is_full  = (count == CW'(DEPTH));
    assign is_empty = (count == '0);
    assign wr_en    = wr_req & ~is_full;
    assign rd_en    = ~is_empty & ~pause;
    assign overflow = wr_req & is_full;

    // Occupancy after this edge, used for the registered flags.
    always_comb begin
        count_nxt = count;
        unique case (1'b1)
            (wr_en & ~rd_en): count_nxt = count + CW'(1);
            (rd_en & ~wr_en): count_nxt = count - CW'(1);
            default:          count_nxt = count;
        endcase
    end

    // Storage array; contents need no reset since pointers are cleared.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            mem[wptr] <= din;
        end
    end

    // Pointers, occupancy, lane output and flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            dout        <= '0;
            empty_f     <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            count       <= count_nxt;
            full        <= (count_nxt == CW'(DEPTH));
            almost_full <= (count_nxt >= CW'(AF_THRESH));
            if (wr_en) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_en) begin
                dout    <= mem[rptr];
                empty_f <= 1'b0;
                rptr    <= rptr + AW'(1);
            end else begin
                empty_f <= 1'b1;
            end
        end
    end

endmodule

module vc_demux_fifo #(
    parameter int DATA_W    = 10,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              push,
    input  logic              pause0,
    input  logic              pause1,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic              emptyF0,
    output logic              emptyF1,
    output logic              full0,
    output logic              full1,
    output logic              almost_full0,
    output logic              almost_full1,
    output logic              error
);

    logic push0;
    logic push1;
    logic ovf0;
    logic ovf1;

    assign push0 = push & ~data_in[8];
    assign push1 = push &  data_in[8];

    vc_fifo #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH)
    ) u_vc0 (
        .clk         (clk),
        .reset       (reset),
        .wr_req      (push0),
        .din         (data_in),
        .pause       (pause0),
        .dout        (out0),
        .empty_f     (emptyF0),
        .full        (full0),
        .almost_full (almost_full0),
        .overflow    (ovf0)
    );

    vc_fifo #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH)
    ) u_vc1 (
        .clk         (clk),
        .reset       (reset),
        .wr_req      (push1),
        .din         (data_in),
        .pause       (pause1),
        .dout        (out1),
        .empty_f     (emptyF1),
        .full        (full1),
        .almost_full (almost_full1),
        .overflow    (ovf1)
    );

    // Sticky overflow: any dropped word latches error until reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            error <= 1'b0;
        end else if (ovf0 | ovf1) begin
            error <= 1'b1;
        end
    end

endmodule
